// File: rtl/brazo_pkg.sv
// Shared definitions for the arm servo blocks.
// Servo pulse limits are common to the PWM generator and capture.
package brazo_pkg;

    localparam int US_PER_S     = 1_000_000;
    localparam int SERVO_MIN_US = 1000;
    localparam int SERVO_MAX_US = 2000;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer plus registered edge detector.
// Edge pulses and level are aligned to the same cycle.
module pwm_in_sync #(
    parameter logic RST_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Reset to RST_LEVEL so a line already high at reset shows no rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RST_LEVEL;
            s2   <= RST_LEVEL;
            s3   <= RST_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s3;

endmodule

// File: rtl/pwm_capture.sv
// Servo PWM high-time capture: width in us and position code.
// Partial pulses after reset, enable or timeout are discarded.
module pwm_capture
    import brazo_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_DIV   = CLK_HZ / US_PER_S,
    parameter int MIN_US     = SERVO_MIN_US,
    parameter int MAX_US     = SERVO_MAX_US,
    parameter int TIMEOUT_US = 25000,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  pwm_in,
    output logic [15:0]           width_us,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  out_of_range,
    output logic                  no_signal
);

    localparam int TW   = $clog2(TICK_DIV + 1);
    localparam int IW   = $clog2(TIMEOUT_US + 1);
    localparam int DMAX = (2 ** DATA_WIDTH) - 1;
    localparam int SPAN = MAX_US - MIN_US;

    localparam logic [15:0]   MIN_W  = 16'(MIN_US);
    localparam logic [15:0]   MAX_W  = 16'(MAX_US);
    localparam logic [TW-1:0] TICK_L = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] TO_L   = IW'(TIMEOUT_US - 1);
    localparam logic [IW-1:0] TO_M   = IW'(TIMEOUT_US);

    logic                  level, rise, fall;
    cap_state_t            state, state_nxt;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [15:0]           hi_cnt, hi_inc, clamped;
    logic [IW-1:0]         idle_cnt;
    logic                  timeout, latch;
    logic [DATA_WIDTH-1:0] code;

    pwm_in_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign tick    = en && (tick_cnt == TICK_L);
    assign timeout = tick && !(rise || fall) && (idle_cnt == TO_L);
    assign latch   = en && (state == HIGH) && fall;
    assign hi_inc  = (tick && hi_cnt != 16'hFFFF) ? hi_cnt + 16'd1 : hi_cnt;

    always_comb begin
        clamped = hi_inc;
        if (hi_inc < MIN_W)
            clamped = MIN_W;
        else if (hi_inc > MAX_W)
            clamped = MAX_W;
        // Constant divisor: folds into multiply/shift logic
        code = DATA_WIDTH'((32'(clamped - MIN_W) * DMAX) / SPAN);
    end

    always_comb begin
        state_nxt = state;
        if (!en || timeout) begin
            state_nxt = WAIT_LOW;
        end else begin
            unique case (state)
                WAIT_LOW:  if (!level) state_nxt = WAIT_RISE;
                WAIT_RISE: if (rise)   state_nxt = HIGH;
                HIGH:      if (fall)   state_nxt = WAIT_RISE;
                default:               state_nxt = WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT_LOW;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
        end else if (!en) begin
            tick_cnt <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (rise || fall)
                idle_cnt <= '0;
            else if (tick && idle_cnt != TO_M)
                idle_cnt <= idle_cnt + IW'(1);

            if (timeout)
                hi_cnt <= '0;
            else if (state == WAIT_RISE && rise)
                hi_cnt <= '0;
            else if (state == HIGH)
                hi_cnt <= hi_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_us     <= '0;
            data         <= '0;
            valid        <= 1'b0;
            out_of_range <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            valid <= latch;
            if (latch) begin
                width_us     <= hi_inc;
                data         <= code;
                out_of_range <= (hi_inc < MIN_W) || (hi_inc > MAX_W);
                no_signal    <= 1'b0;
            end else if (timeout) begin
                no_signal    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at 2 clk per us tick.
// Timeout shortened to 4000 us to keep the run short.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n, en, pwm_in;
    logic [15:0] width_us;
    logic [7:0]  data;
    logic        valid, out_of_range, no_signal;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int v0;
    int cap_w, cap_d, cap_oor, cap_ns;

    int rng_us [4] = '{1000, 2000, 2500, 500};
    int rng_d  [4] = '{0, 255, 255, 0};
    int rng_o  [4] = '{0, 0, 1, 1};

    always #5 clk = ~clk;

    pwm_capture #(
        .CLK_HZ     (2_000_000),
        .TIMEOUT_US (4000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_in       (pwm_in),
        .width_us     (width_us),
        .data         (data),
        .valid        (valid),
        .out_of_range (out_of_range),
        .no_signal    (no_signal)
    );

    always @(negedge clk) begin
        if (valid) begin
            vcnt    <= vcnt + 1;
            cap_w   <= int'(width_us);
            cap_d   <= int'(data);
            cap_oor <= int'(out_of_range);
            cap_ns  <= int'(no_signal);
        end
    end

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(int clks);
        repeat (clks) @(negedge clk);
    endtask

    // High for hi_us ticks plus one extra clk to exercise the floor
    task automatic pulse(int hi_us, int lo_us);
        pwm_in = 1'b1;
        hold(2 * hi_us + 1);
        pwm_in = 1'b0;
        hold(2 * lo_us + 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;
        hold(3);
        check("rst_width", int'(width_us), 0);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_oor", int'(out_of_range), 0);
        check("rst_nosig", int'(no_signal), 1);
        rst_n = 1'b1;
        hold(5);

        for (int i = 0; i < 3; i++) begin
            v0 = vcnt;
            pulse(1500, 500);
            check("p1500_cnt", vcnt - v0, 1);
            check("p1500_w", cap_w, 1500);
            check("p1500_d", cap_d, 127);
            check("p1500_oor", cap_oor, 0);
            check("p1500_ns", cap_ns, 0);
        end

        for (int i = 0; i < 4; i++) begin
            v0 = vcnt;
            pulse(rng_us[i], 500);
            check("rng_cnt", vcnt - v0, 1);
            check("rng_w", cap_w, rng_us[i]);
            check("rng_d", cap_d, rng_d[i]);
            check("rng_oor", cap_oor, rng_o[i]);
        end

        pulse(1500, 0);
        hold(2 * 3900);
        check("to_lo_early", int'(no_signal), 0);
        hold(2 * 200);
        check("to_lo_ns", int'(no_signal), 1);
        check("to_lo_d", int'(data), 127);
        check("to_lo_w", int'(width_us), 1500);

        pulse(1500, 500);
        check("pre_hi_ns", int'(no_signal), 0);
        v0 = vcnt;
        pwm_in = 1'b1;
        hold(2 * 5000);
        check("to_hi_ns", int'(no_signal), 1);
        check("to_hi_cnt", vcnt - v0, 0);
        pwm_in = 1'b0;
        hold(2 * 500);
        check("to_hi_fall", vcnt - v0, 0);
        check("to_hi_w", int'(width_us), 1500);

        v0 = vcnt;
        pwm_in = 1'b1;
        hold(2 * 300);
        rst_n = 1'b0;
        hold(2);
        check("mid_rst_w", int'(width_us), 0);
        check("mid_rst_ns", int'(no_signal), 1);
        rst_n = 1'b1;
        hold(2 * 1200);
        pwm_in = 1'b0;
        hold(2 * 500);
        check("mid_rst_cnt", vcnt - v0, 0);
        v0 = vcnt;
        pulse(1200, 500);
        check("p1200_cnt", vcnt - v0, 1);
        check("p1200_w", cap_w, 1200);
        check("p1200_d", cap_d, 51);
        check("p1200_oor", cap_oor, 0);

        v0 = vcnt;
        pwm_in = 1'b1;
        hold(2 * 900);
        en = 1'b0;
        hold(2 * 900 + 1);
        pwm_in = 1'b0;
        hold(2 * 500);
        check("en_cnt", vcnt - v0, 0);
        check("en_w", int'(width_us), 1200);
        check("en_d", int'(data), 51);
        check("en_ns", int'(no_signal), 0);
        en = 1'b1;
        hold(10);

        v0 = vcnt;
        pwm_in = 1'b1;
        hold(2 * 1500 + 1);
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lat_3clk", int'(valid), 0);
        @(posedge clk);
        #1 check("lat_4clk", int'(valid), 1);
        check("lat_w", int'(width_us), 1500);
        check("lat_d", int'(data), 127);
        @(posedge clk);
        #1 check("lat_5clk", int'(valid), 0);
        hold(2 * 500);
        check("lat_cnt", vcnt - v0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator: measures the high time of an incoming servo-style PWM pulse train.
- Converts the high time into microseconds and into a DATA_WIDTH position code, using the same 1000–2000 µs ↔ 0–255 mapping the generator uses.
- Sits on a GPIO input of the arm top level. Used to read back an RC receiver or a servo-feedback line, and to loop-test our own PWM outputs.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_DIV, 50, clk cycles per 1 µs measurement tick (CLK_HZ/1_000_000).
- MIN_US, 1000, pulse width mapped to data 0.
- MAX_US, 2000, pulse width mapped to data 2^DATA_WIDTH-1.
- TIMEOUT_US, 25000, µs without any edge before no_signal asserts.
- DATA_WIDTH, 8, position code width.

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 at top).
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  capture enable (SW[0] at top).
- pwm_in  in  1  asynchronous PWM input pin.
- width_us  out  16  last measured high time in µs, saturating at 16'hFFFF.
- data  out  DATA_WIDTH  last position code.
- valid  out  1  one-cycle strobe when width_us/data update.
- out_of_range  out  1  last pulse was < MIN_US or > MAX_US.
- no_signal  out  1  no edge seen for TIMEOUT_US.

Behaviour:
- Reset values:
  - width_us=0, data=0, valid=0, out_of_range=0.
  - no_signal=1.
  - FSM state = WAIT_LOW; all counters 0.
- Input conditioning:
  - 2-FF synchronizer on pwm_in, then a registered copy for edge detection.
  - rise/fall are one-cycle pulses, valid 3 clk after the pin transition is first sampled.
- Tick generator:
  - Counts 0..TICK_DIV-1; emits tick on the wrap.
  - Cleared to 0 on every rise, so measured width = floor(high_clks/TICK_DIV).
- FSM states:
  - WAIT_LOW: wait for synced level 0, then go to WAIT_RISE. A pulse already high at reset or enable is discarded, never half-measured.
  - WAIT_RISE: on rise, clear hi_cnt, go to HIGH.
  - HIGH: hi_cnt += 1 per tick, saturating at 16'hFFFF. On fall, latch, go to WAIT_RISE.
- Latch action on fall:
  - width_us <= hi_cnt.
  - clamped = min(max(hi_cnt, MIN_US), MAX_US).
  - data <= ((clamped-MIN_US)*(2^DATA_WIDTH-1))/(MAX_US-MIN_US), truncating. The divisor is constant, so there is no runtime divider.
  - out_of_range <= (hi_cnt<MIN_US)|(hi_cnt>MAX_US).
  - valid pulses exactly 1 cycle, in the cycle after fall is detected.
  - Total latency: 4 clk from the first clk edge that samples pwm_in low.
- Timeout:
  - idle_cnt counts ticks since the last rise or fall; it clears on either edge.
  - When idle_cnt reaches TIMEOUT_US: no_signal <= 1, state <= WAIT_LOW, hi_cnt <= 0.
  - width_us and data hold their last values.
  - A stuck-high line therefore times out without producing valid.
- no_signal clears in the same cycle valid pulses (first complete pulse).
- en=0:
  - State forced to WAIT_LOW, counters cleared, valid=0.
  - width_us, data, out_of_range and no_signal hold.
- Simultaneous events:
  - Timeout and edge in the same cycle: the edge wins and idle_cnt clears.
  - en falling in the same cycle as a fall edge: en wins, no valid.
- Reset mid-pulse: all outputs return to reset values immediately (async); the next measurement starts only after a low is seen.

Decomposition:
- Package brazo_pkg:
  - FSM state enum (WAIT_LOW, WAIT_RISE, HIGH).
  - US_PER_S constant.
  - Default servo limits SERVO_MIN_US=1000 and SERVO_MAX_US=2000, shared with the PWM generator.
- Sub-module pwm_in_sync: 2-FF synchronizer plus edge detector. Outputs are level, rise and fall; reusable for KEY inputs.

Test Plan:
- 1500 µs high / 20 ms period ×3 → valid once per period, width_us=1500, data=127, out_of_range=0, no_signal drops at first valid.
- 1000 µs pulse → data=0. 2000 µs pulse → data=255. Both out_of_range=0.
- 2500 µs pulse → width_us=2500, data=255, out_of_range=1. 500 µs pulse → width_us=500, data=0, out_of_range=1.
- Line held low 25 ms after a valid 1500 µs pulse → no_signal=1 at tick 25000, data stays 127. Line held high 30 ms → no_signal=1, no valid.
- Reset released while pwm_in high mid-pulse → that pulse produces no valid; next 1200 µs pulse → width_us=1200, data=51.
- Drop en during a 1800 µs pulse → no valid, outputs hold. Restore en → next pulse is measured normally. Check valid lands exactly 4 clk after pwm_in falls.
